intra_mb_scheduler: RTL and testbench
=====================================

# intra_mb_scheduler

Frame-level sequencer for the intra-prediction path. It walks every macroblock of a frame in raster order and runs the same steps for each one. First it requests the neighbour-pixel fetch. Then it starts the predictor/SAD stage and waits for it to finish. Finally it pulses the residue saver's `enable` with the matching `mbnumber` and captures the chosen mode. It owns macroblock numbering and neighbour-availability flags, and it signals frame completion to the encoder top.

## Interface
Parameters:
- `WIDTH`, 720: frame height in pixels (rows).
- `LENGTH`, 1280: frame width in pixels (columns).
- `MB_SIZE_L`, 8: macroblock width; legal values 4, 8, 16.
- `MB_SIZE_W`, 8: macroblock height; legal values 4, 8, 16.
- `MBN_W`, 14: width of the macroblock index; must satisfy 2^MBN_W ≥ MB_COLS·MB_ROWS.
- `PRED_TIMEOUT`, 1024: watchdog limit in cycles (used only with the macro below).

Ports:
- `clk`, in, 1: single clock; all logic is posedge.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: one-cycle pulse that begins a frame; ignored while `busy`.
- `busy`, out, 1: high from the cycle after an accepted `start` until `frame_done`.
- `frame_done`, out, 1: one-cycle pulse after the last macroblock's mode is captured.
- `fetch_req`, out, 1: neighbour/source fetch request for the current macroblock.
- `fetch_ack`, in, 1: fetch complete.
- `pred_start`, out, 1: one-cycle pulse that launches prediction and SAD evaluation.
- `pred_done`, in, 1: SADs and residues are valid and held stable.
- `save_enable`, out, 1: one-cycle pulse to the saver's `enable`.
- `mbnumber`, out, MBN_W: current macroblock index, y·MB_COLS + x.
- `mb_x`, out, 8: macroblock column index.
- `mb_y`, out, 8: macroblock row index.
- `avail_left`, out, 1: 1 when mb_x ≠ 0.
- `avail_top`, out, 1: 1 when mb_y ≠ 0.
- `mode_in`, in, 3: saver's `mode` output.
- `last_mode`, out, 3: mode captured for the most recently completed macroblock.
- `pred_timeout`, out, 1: sticky error flag (used only with the macro below).

## Operation
- Derived constants:
  - MB_COLS = LENGTH/MB_SIZE_L
  - MB_ROWS = WIDTH/MB_SIZE_W
  - MB_TOTAL = MB_COLS·MB_ROWS
- States and transitions:
  - IDLE → FETCH on `start`. Counters clear to 0 on entry to FETCH from IDLE.
  - FETCH: `fetch_req`=1. Moves to PRED in the cycle `fetch_ack`=1 is sampled.
  - PRED: `pred_start`=1 for exactly one cycle, then → WAIT.
  - WAIT: moves to SAVE when `pred_done`=1. A `pred_done` that is already high on entry is accepted.
  - SAVE: `save_enable`=1 for one cycle, with `mbnumber`, `mb_x` and `mb_y` held → CAPT.
  - CAPT: `last_mode` ← `mode_in`. If `mbnumber` = MB_TOTAL−1, go to DONE; otherwise advance the counters and go to FETCH.
  - DONE: `frame_done`=1 for one cycle → IDLE.
- Counter advance:
  - mb_x increments; at MB_COLS−1 it wraps to 0 and mb_y increments.
  - `mbnumber` increments by 1. It is never computed with a multiply.
- `avail_left` and `avail_top` are registered and decoded from the counters. They are stable from FETCH through CAPT.
- `start` is ignored in every state other than IDLE. `fetch_ack` and `pred_done` are ignored outside FETCH and WAIT respectively.
- Reset values: state IDLE, and every output 0, including `last_mode` and `pred_timeout`.
- Reset asserted mid-frame aborts immediately. No `frame_done` is issued, and the next `start` begins again at macroblock 0.

## Timing
- All outputs are registered.
- `fetch_req` rises the cycle after the accepted `start` and falls the cycle after `fetch_ack` is sampled.
- `pred_start` pulses the cycle after `fetch_ack` is sampled.
- `save_enable` pulses the cycle after `pred_done` is sampled.
- `last_mode` updates one cycle after `save_enable`, which matches the saver's one-cycle mode latency.
- Minimum per-macroblock cost is 5 cycles, with `fetch_ack` and `pred_done` returning in 0 cycles.
- Next-macroblock `fetch_req` rises the cycle after CAPT.
- `frame_done` occurs 1 cycle after the final CAPT. `busy` falls together with `frame_done`.

## Configuration
- `INTRA_SCHED_TIMEOUT_EN` defined:
  - A cycle counter runs while in WAIT.
  - When it reaches PRED_TIMEOUT, the block sets `pred_timeout` (sticky until the next accepted `start`).
  - It then skips SAVE: no `save_enable`, and `last_mode` is unchanged.
  - It advances to the next macroblock as if CAPT had completed.
- `INTRA_SCHED_TIMEOUT_EN` undefined: WAIT waits indefinitely and `pred_timeout` is tied to 0.

## Structure
- Shared package `intra_pkg` holds:
  - the state enum `sched_state_t`;
  - `mode_t` (3-bit);
  - helper functions for MB_COLS, MB_ROWS and MB_TOTAL, which are also used by the saver and predictor.
- One sub-module, `intra_mb_counter`: raster x/y/index counter with clear, advance and last-macroblock flag.

## Test plan
Bench parameters: LENGTH=32, WIDTH=16, MB 8×8, giving 4×2 = 8 macroblocks.
- Basic frame: `start`, with `fetch_ack` and `pred_done` returned immediately → 8 `save_enable` pulses with `mbnumber` 0..7, `frame_done` at cycle 41, `busy` high for 40 cycles.
- Availability: check each `save_enable` → (avail_left, avail_top) is (0,0) for MB0, (1,0) for MB1–3, (0,1) for MB4, (1,1) for MB7.
- Mode capture: `mode_in` = mbnumber mod 8, driven one cycle after `save_enable` → `last_mode` follows 0..7.
- Delayed handshakes and spurious inputs: `fetch_ack` late by 3 cycles, `pred_done` late by 10, plus a spurious `start` in WAIT → no extra pulses, sequence unchanged.
- Reset mid-frame: assert reset during WAIT of MB5 → outputs 0 immediately; next `start` gives `mbnumber`=0.
- Watchdog (macro on, PRED_TIMEOUT=16): `pred_done` held 0 for MB2 → `pred_timeout`=1 after 16 WAIT cycles, no `save_enable` for MB2, frame still completes.

Source files
------------

// File: rtl/intra_pkg.sv
// Shared types and frame-geometry helpers for the intra-prediction path
// (scheduler, predictor and residue saver).
package intra_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PRED  = 3'd2,
    S_WAIT  = 3'd3,
    S_SAVE  = 3'd4,
    S_CAPT  = 3'd5,
    S_DONE  = 3'd6
  } sched_state_t;

  typedef logic [2:0] mode_t;

  function automatic int mb_cols(input int length, input int mb_l);
    return length / mb_l;
  endfunction

  function automatic int mb_rows(input int width, input int mb_w);
    return width / mb_w;
  endfunction

  function automatic int mb_total(input int length, input int width,
                                  input int mb_l, input int mb_w);
    return mb_cols(length, mb_l) * mb_rows(width, mb_w);
  endfunction

endpackage

// File: rtl/intra_mb_counter.sv
// Raster-order macroblock counter: column/row/index with clear, advance,
// registered neighbour-availability flags and a last-macroblock flag.
module intra_mb_counter
  import intra_pkg::*;
#(
  parameter int MB_COLS  = 160,
  parameter int MB_TOTAL = 14400,
  parameter int MBN_W    = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [MBN_W-1:0] mbnumber_o,
  output logic [7:0]       mb_x_o,
  output logic [7:0]       mb_y_o,
  output logic             avail_left_o,
  output logic             avail_top_o,
  output logic             last_o
);

  localparam logic [7:0]       X_LAST = 8'(MB_COLS - 1);
  localparam logic [MBN_W-1:0] N_LAST = MBN_W'(MB_TOTAL - 1);

  logic [MBN_W-1:0] n_q, n_d;
  logic [7:0]       x_q, x_d, y_q, y_d;
  logic             al_q, at_q;

  // The linear index is its own incrementer, so no y*MB_COLS product is needed.
  always_comb begin
    n_d = n_q;
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      n_d = '0;
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      n_d = n_q + MBN_W'(1);
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_q  <= '0;
      x_q  <= '0;
      y_q  <= '0;
      al_q <= 1'b0;
      at_q <= 1'b0;
    end else begin
      n_q  <= n_d;
      x_q  <= x_d;
      y_q  <= y_d;
      al_q <= (x_d != 8'd0);
      at_q <= (y_d != 8'd0);
    end
  end

  assign mbnumber_o   = n_q;
  assign mb_x_o       = x_q;
  assign mb_y_o       = y_q;
  assign avail_left_o = al_q;
  assign avail_top_o  = at_q;
  assign last_o       = (n_q == N_LAST);

endmodule

// File: rtl/intra_mb_scheduler.sv
// Frame-level sequencer for intra prediction: fetch -> predict -> save -> capture
// per macroblock in raster order. Optional WAIT watchdog: INTRA_SCHED_TIMEOUT_EN.
module intra_mb_scheduler
  import intra_pkg::*;
#(
  parameter int WIDTH        = 720,
  parameter int LENGTH       = 1280,
  parameter int MB_SIZE_L    = 8,
  parameter int MB_SIZE_W    = 8,
  parameter int MBN_W        = 14,
  parameter int PRED_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  output logic             fetch_req,
  input  logic             fetch_ack,
  output logic             pred_start,
  input  logic             pred_done,
  output logic             save_enable,
  output logic [MBN_W-1:0] mbnumber,
  output logic [7:0]       mb_x,
  output logic [7:0]       mb_y,
  output logic             avail_left,
  output logic             avail_top,
  input  mode_t            mode_in,
  output mode_t            last_mode,
  output logic             pred_timeout
);

  localparam int MB_COLS  = mb_cols(LENGTH, MB_SIZE_L);
  localparam int MB_TOTAL = mb_total(LENGTH, WIDTH, MB_SIZE_L, MB_SIZE_W);

  if (!(MB_SIZE_L == 4 || MB_SIZE_L == 8 || MB_SIZE_L == 16) ||
      !(MB_SIZE_W == 4 || MB_SIZE_W == 8 || MB_SIZE_W == 16) ||
      (MB_TOTAL > (2 ** MBN_W)) || (PRED_TIMEOUT < 1)) begin : g_bad_params
    $error("intra_mb_scheduler: illegal parameter combination");
  end

  sched_state_t state_q, state_d;
  logic         cnt_clr, cnt_adv, mb_last, wd_hit;
  logic         busy_q, fetch_req_q, pred_start_q, save_enable_q, frame_done_q;
  mode_t        last_mode_q;

  intra_mb_counter #(
    .MB_COLS  (MB_COLS),
    .MB_TOTAL (MB_TOTAL),
    .MBN_W    (MBN_W)
  ) u_counter (
    .clk_i        (clk),
    .rst_i        (reset),
    .clr_i        (cnt_clr),
    .adv_i        (cnt_adv),
    .mbnumber_o   (mbnumber),
    .mb_x_o       (mb_x),
    .mb_y_o       (mb_y),
    .avail_left_o (avail_left),
    .avail_top_o  (avail_top),
    .last_o       (mb_last)
  );

`ifdef INTRA_SCHED_TIMEOUT_EN
  localparam int             WD_W    = $clog2(PRED_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(PRED_TIMEOUT - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            pto_q, pto_d;

  // Counts cycles spent in WAIT; it never wraps because WAIT is left on the hit.
  always_comb begin
    wd_d  = (state_q == S_WAIT) ? wd_q + WD_W'(1) : '0;
    pto_d = pto_q;
    if (state_q == S_IDLE && start) pto_d = 1'b0;
    else if (wd_hit)                 pto_d = 1'b1;
  end

  assign wd_hit = (state_q == S_WAIT) && !pred_done && (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      pto_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      pto_q <= pto_d;
    end
  end

  assign pred_timeout = pto_q;
`else
  assign wd_hit       = 1'b0;
  assign pred_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_adv = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_clr = 1'b1;
        end
      end
      S_FETCH: if (fetch_ack) state_d = S_PRED;
      S_PRED:  state_d = S_WAIT;
      S_WAIT: begin
        if (pred_done) begin
          state_d = S_SAVE;
        end else if (wd_hit) begin
          // A timed-out macroblock is retired exactly like a completed CAPT.
          if (mb_last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            cnt_adv = 1'b1;
          end
        end
      end
      S_SAVE:  state_d = S_CAPT;
      S_CAPT: begin
        if (mb_last) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          cnt_adv = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are flops decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      fetch_req_q   <= 1'b0;
      pred_start_q  <= 1'b0;
      save_enable_q <= 1'b0;
      frame_done_q  <= 1'b0;
      last_mode_q   <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= (state_d != S_IDLE) && (state_d != S_DONE);
      fetch_req_q   <= (state_d == S_FETCH);
      pred_start_q  <= (state_d == S_PRED);
      save_enable_q <= (state_d == S_SAVE);
      frame_done_q  <= (state_d == S_DONE);
      if (state_q == S_CAPT) last_mode_q <= mode_in;
    end
  end

  assign busy        = busy_q;
  assign fetch_req   = fetch_req_q;
  assign pred_start  = pred_start_q;
  assign save_enable = save_enable_q;
  assign frame_done  = frame_done_q;
  assign last_mode   = last_mode_q;

endmodule

// File: tb/tb_intra_mb_scheduler.sv
// Self-checking bench for intra_mb_scheduler on a 32x16 frame of 8x8 macroblocks.
module tb_intra_mb_scheduler;

  localparam int PTO  = 16;
  localparam int NMB  = 8;
  localparam int COLS = 4;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        reset, start, fetch_ack, pred_done;
  logic        busy, frame_done, fetch_req, pred_start, save_enable;
  logic [13:0] mbnumber;
  logic [7:0]  mb_x, mb_y;
  logic        avail_left, avail_top, pred_timeout;
  logic [2:0]  mode_in, last_mode;

  always #5 clk = ~clk;

  intra_mb_scheduler #(
    .WIDTH(16), .LENGTH(32), .MB_SIZE_L(8), .MB_SIZE_W(8), .MBN_W(14), .PRED_TIMEOUT(PTO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack), .pred_start(pred_start),
    .pred_done(pred_done), .save_enable(save_enable), .mbnumber(mbnumber),
    .mb_x(mb_x), .mb_y(mb_y), .avail_left(avail_left), .avail_top(avail_top),
    .mode_in(mode_in), .last_mode(last_mode), .pred_timeout(pred_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Per-frame stimulus plan: fetch/pred latencies (dp<0 = never) and modes.
  int         df[NMB];
  int         dp[NMB];
  logic [2:0] modes[NMB];
  bit         spurious;

  // Expected per-cycle timeline derived from the plan.
  bit exp_fr[MAXC];
  bit exp_ps[MAXC];
  bit exp_se[MAXC];
  int exp_se_mb[MAXC];
  int exp_done;
  int to_cyc;

  int cap_mbn[NMB], cap_x[NMB], cap_y[NMB], cap_al[NMB], cap_at[NMB], cap_cyc[NMB], cap_mode[NMB];
  int cap_n, busy_n, done_at;

  typedef struct {
    int mbn; int x; int y; int al; int at; int save_cyc; int mode;
  } vec_t;
  vec_t tbl[NMB];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle 0 is the edge that samples start; each macroblock costs
  // (df+1) fetch + 1 pred + (dp+1) wait + save + capt cycles.
  function automatic void build_model();
    int t, r, p;
    for (int c = 0; c < MAXC; c++) begin
      exp_fr[c] = 0; exp_ps[c] = 0; exp_se[c] = 0; exp_se_mb[c] = -1;
    end
    to_cyc = 0;
    t = 0;
    for (int i = 0; i < NMB; i++) begin
      r = t + 1;
      for (int k = 0; k <= df[i]; k++) exp_fr[r + k] = 1;
      p = r + df[i] + 1;
      exp_ps[p] = 1;
      if (dp[i] < 0) begin
        if (to_cyc == 0) to_cyc = p + PTO + 1;
        t = p + PTO;
      end else begin
        exp_se[p + 2 + dp[i]]    = 1;
        exp_se_mb[p + 2 + dp[i]] = i;
        t = p + 3 + dp[i];
      end
    end
    exp_done = t + 1;
  endfunction

  task automatic run_frame(input int abort_mb);
    int  ack_cyc, pd_cyc, pd_early, fi, pi, p_abort, mi;
    bit  waiting, prev_fr;
    build_model();
    ack_cyc = -1; pd_cyc = -1; pd_early = -1; fi = 0; pi = 0; p_abort = -1;
    waiting = 0; prev_fr = 0; cap_n = 0; busy_n = 0; done_at = -1;
    fetch_ack = 0; pred_done = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c <= exp_done; c++) begin
      cyc = c;
      chk("busy", busy, (c < exp_done) ? 1 : 0);
      chk("fetch_req", fetch_req, exp_fr[c]);
      chk("pred_start", pred_start, exp_ps[c]);
      chk("save_enable", save_enable, exp_se[c]);
      chk("frame_done", frame_done, (c == exp_done) ? 1 : 0);
      chk("pred_timeout", pred_timeout, (to_cyc > 0 && c >= to_cyc) ? 1 : 0);
      if (busy) busy_n++;
      if (frame_done) done_at = c;
      if (save_enable && exp_se[c]) begin
        mi = exp_se_mb[c];
        chk("mbnumber", mbnumber, mi);
        chk("mb_x", mb_x, mi % COLS);
        chk("mb_y", mb_y, mi / COLS);
        chk("avail_left", avail_left, (mi % COLS) != 0 ? 1 : 0);
        chk("avail_top", avail_top, (mi / COLS) != 0 ? 1 : 0);
      end
      if (save_enable && cap_n < NMB) begin
        cap_mbn[cap_n] = mbnumber; cap_x[cap_n] = mb_x; cap_y[cap_n] = mb_y;
        cap_al[cap_n] = avail_left; cap_at[cap_n] = avail_top; cap_cyc[cap_n] = c;
        cap_mode[cap_n] = -1;
        cap_n++;
      end
      if (c >= 3 && exp_se[c - 2]) begin
        chk("last_mode", last_mode, modes[exp_se_mb[c - 2]]);
        if (cap_n > 0) cap_mode[cap_n - 1] = last_mode;
      end
      // Responder: react to the request handshakes with the planned latencies.
      if (fetch_req && !prev_fr) begin
        waiting = 0;
        ack_cyc = (fi < NMB) ? c + df[fi] : c;
        fi++;
      end
      if (pred_start) begin
        waiting  = 1;
        pd_cyc   = (pi < NMB && dp[pi] >= 0) ? c + 1 + dp[pi] : -1;
        pd_early = (pi < NMB && dp[pi] == 0) ? c : -1;
        if (pi == abort_mb) p_abort = c;
        pi++;
      end
      if (fetch_req) fetch_ack = (c == ack_cyc);
      else           fetch_ack = spurious && ($urandom_range(0, 2) == 0);
      if (waiting) begin
        pred_done = (c == pd_cyc) || (c == pd_early);
        if (c == pd_cyc) waiting = 0;
      end else begin
        pred_done = spurious && ($urandom_range(0, 2) == 0);
      end
      if (c >= 2 && exp_se[c - 1]) mode_in = modes[exp_se_mb[c - 1]];
      else                         mode_in = 3'($urandom);
      start = spurious && (c < exp_done) && (waiting || $urandom_range(0, 4) == 0);
      prev_fr = fetch_req;
      if (abort_mb >= 0 && p_abort >= 0 && c == p_abort + 3) break;
      @(posedge clk); #1;
    end
    start = 0; fetch_ack = 0; pred_done = 0;
    if (abort_mb < 0) begin
      cyc = exp_done + 1;
      chk("idle_busy", busy, 0);
      chk("idle_frame_done", frame_done, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_fetch_req"}, fetch_req, 0);
    chk({tag, "_pred_start"}, pred_start, 0);
    chk({tag, "_save_enable"}, save_enable, 0);
    chk({tag, "_mbnumber"}, mbnumber, 0);
    chk({tag, "_mb_x"}, mb_x, 0);
    chk({tag, "_mb_y"}, mb_y, 0);
    chk({tag, "_avail_left"}, avail_left, 0);
    chk({tag, "_avail_top"}, avail_top, 0);
    chk({tag, "_last_mode"}, last_mode, 0);
    chk({tag, "_pred_timeout"}, pred_timeout, 0);
  endtask

  task automatic plan_zero();
    for (int i = 0; i < NMB; i++) begin
      df[i] = 0; dp[i] = 0; modes[i] = 3'(i);
    end
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0,  4, 0};
    tbl[1] = '{1, 1, 0, 1, 0,  9, 1};
    tbl[2] = '{2, 2, 0, 1, 0, 14, 2};
    tbl[3] = '{3, 3, 0, 1, 0, 19, 3};
    tbl[4] = '{4, 0, 1, 0, 1, 24, 4};
    tbl[5] = '{5, 1, 1, 1, 1, 29, 5};
    tbl[6] = '{6, 2, 1, 1, 1, 34, 6};
    tbl[7] = '{7, 3, 1, 1, 1, 39, 7};

    reset = 1; start = 0; fetch_ack = 0; pred_done = 0; mode_in = 0; spurious = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 reset = 0;

    // Basic frame with immediate handshakes, compared against the table.
    plan_zero();
    run_frame(-1);
    chk("cap_count", cap_n, NMB);
    for (int i = 0; i < NMB; i++) begin
      chk("tbl_mbn", cap_mbn[i], tbl[i].mbn);
      chk("tbl_x", cap_x[i], tbl[i].x);
      chk("tbl_y", cap_y[i], tbl[i].y);
      chk("tbl_avail_left", cap_al[i], tbl[i].al);
      chk("tbl_avail_top", cap_at[i], tbl[i].at);
      chk("tbl_save_cycle", cap_cyc[i], tbl[i].save_cyc);
      chk("tbl_last_mode", cap_mode[i], tbl[i].mode);
    end
    chk("busy_cycles", busy_n, 40);
    chk("frame_done_cycle", done_at, 41);

    // Late handshakes plus spurious start/ack/done inputs.
    plan_zero();
    df[2] = 3; dp[2] = 10;
    spurious = 1;
    run_frame(-1);
    spurious = 0;

    // Reset during WAIT of MB5 aborts immediately.
    plan_zero();
    dp[5] = 20;
    run_frame(5);
    #2 reset = 1;
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge clk);
    #2 reset = 0;
    plan_zero();
    run_frame(-1);

    // Randomized latencies and modes against the timeline model.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NMB; i++) begin
        df[i] = $urandom_range(0, 3);
        dp[i] = $urandom_range(0, 5);
        modes[i] = 3'($urandom);
      end
      spurious = 1;
      run_frame(-1);
    end
    spurious = 0;

`ifdef INTRA_SCHED_TIMEOUT_EN
    // MB2 never completes prediction: watchdog skips it, frame still ends.
    plan_zero();
    for (int i = 0; i < NMB; i++) modes[i] = 3'(7 - i);
    dp[2] = -1;
    run_frame(-1);
    chk("timeout_sticky", pred_timeout, 1);
    plan_zero();
    run_frame(-1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
